// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply/divide unit feeding the Hi/Lo
//               registers. Radix-2 Booth multiply and restoring divide, one
//               step per cycle, WIDTH steps per operation.
//               Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned
//               input for MULTU/DIVU behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             dzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_MULT   = 2'd1;
    localparam logic [1:0] c_DIV    = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    // Upper accumulator carries two guard bits so the Booth add/subtract of a
    // most-negative (or zero-extended unsigned) multiplicand cannot overflow.
    localparam int                c_AW        = WIDTH + 2;
    localparam logic [CNT_W-1:0]  c_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [c_AW-1:0]  r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_booth;
    logic [c_AW-1:0]  r_opb;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_unsigned;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic             r_dzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_unsigned;
    logic             w_idle;
    logic             w_accept_mult;
    logic             w_accept_div;
    logic             w_div_zero;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [c_AW-1:0]  w_booth_sum;
    logic [c_AW-1:0]  w_rem_shift;
    logic [c_AW-1:0]  w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_part;
    logic [WIDTH-1:0] w_mult_hi;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_unsigned = is_unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    // Start decode: multiply has priority, a zero divisor never leaves IDLE.
    assign w_idle        = (r_state == c_IDLE);
    assign w_accept_mult = w_idle && mult_start;
    assign w_accept_div  = w_idle && !mult_start && div_start && (src_b != '0);
    assign w_div_zero    = w_idle && !mult_start && div_start && (src_b == '0);

    // Operand magnitudes for the divider; signs are ignored for DIVU.
    assign w_a_neg = !w_unsigned && src_a[WIDTH-1];
    assign w_b_neg = !w_unsigned && src_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    // Booth step: inspect the multiplier LSB and the extra bit.
    always_comb begin
        w_booth_sum = r_acc_hi;
        case ({r_acc_lo[0], r_booth})
            2'b01:   w_booth_sum = r_acc_hi + r_opb;
            2'b10:   w_booth_sum = r_acc_hi - r_opb;
            default: w_booth_sum = r_acc_hi;
        endcase
    end

    // Restoring divide step: shift in the next dividend bit and trial-subtract.
    assign w_rem_shift = {1'b0, r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    assign w_trial     = w_rem_shift - r_opb;
    assign w_fits      = !w_trial[c_AW-1];

    // Final result shaping: MULTU correction and divide sign fix-up.
    assign w_rem_part = r_acc_hi[WIDTH-1:0];
    assign w_mult_hi  = w_rem_part + ((r_unsigned && r_b_msb) ? r_opb[WIDTH-1:0] : '0);
    assign w_div_lo   = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_div_hi   = r_neg_r ? -w_rem_part : w_rem_part;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: WIDTH steps in MULT/DIV, then a single FINISH cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept_mult) begin
                    w_next_state = c_MULT;
                end else if (w_accept_div) begin
                    w_next_state = c_DIV;
                end
            end
            c_MULT, c_DIV: begin
                if (r_cnt == c_LAST_STEP) begin
                    w_next_state = c_FINISH;
                end
            end
            c_FINISH: w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Datapath, status flags and the architectural Hi/Lo registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_booth    <= 1'b0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_unsigned <= 1'b0;
            r_b_msb    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dzero    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done  <= 1'b0;
            r_dzero <= w_div_zero;
            r_busy  <= (r_state == c_MULT) || (r_state == c_DIV);
            case (r_state)
                c_IDLE: begin
                    if (w_accept_mult) begin
                        r_cnt      <= '0;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= src_b;
                        r_booth    <= 1'b0;
                        r_opb      <= w_unsigned ? {2'b00, src_a}
                                                 : {{2{src_a[WIDTH-1]}}, src_a};
                        r_is_div   <= 1'b0;
                        r_unsigned <= w_unsigned;
                        r_b_msb    <= src_b[WIDTH-1];
                    end else if (w_accept_div) begin
                        r_cnt      <= '0;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_a_mag;
                        r_booth    <= 1'b0;
                        r_opb      <= {2'b00, w_b_mag};
                        r_is_div   <= 1'b1;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_unsigned <= w_unsigned;
                        r_b_msb    <= src_b[WIDTH-1];
                    end
                end
                c_MULT: begin
                    r_acc_hi <= {w_booth_sum[c_AW-1], w_booth_sum[c_AW-1:1]};
                    r_acc_lo <= {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_booth  <= r_acc_lo[0];
                    r_cnt    <= r_cnt + c_CNT_ONE;
                end
                c_DIV: begin
                    r_acc_hi <= w_fits ? w_trial : w_rem_shift;
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
                    r_cnt    <= r_cnt + c_CNT_ONE;
                end
                c_FINISH: begin
                    r_done <= 1'b1;
                    r_hi   <= r_is_div ? w_div_hi : w_mult_hi;
                    r_lo   <= r_is_div ? w_div_lo : r_acc_lo;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign dzero = r_dzero;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide datapath block. It responds to the control unit's MULT_on/DIV_on start requests and returns busy/done/dzero status. Results are written to the Hi and Lo registers used by MFHI/MFLO. It sits beside the ALU in the datapath; the control unit waits in an execute state until done or dzero.

Parameters:
WIDTH, 32, operand width in bits; Hi and Lo are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high.
mult_start  input  1  single-cycle request for a signed multiply (MULT).
div_start  input  1  single-cycle request for a signed divide (DIV).
src_a  input  WIDTH  multiplicand / dividend; sampled only on an accepted start.
src_b  input  WIDTH  multiplier / divisor; sampled only on an accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; hi and lo hold the new result in the same cycle.
dzero  output  1  one-cycle pulse: divide by zero detected.
hi  output  WIDTH  product upper half / remainder.
lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. While reset is high:
  - state = IDLE.
  - busy, done and dzero = 0.
  - hi and lo = 0.
  - Counter and internal operand registers = 0.
  - Reset mid-operation aborts immediately: no done, no partial result reaches hi/lo.
- FSM states: IDLE, MULT, DIV, FINISH.
- IDLE:
  - mult_start = 1: latch operands, go to MULT.
  - div_start = 1 with src_b != 0: latch operands, go to DIV.
  - div_start = 1 with src_b == 0: stay in IDLE, pulse dzero in the next cycle; hi/lo unchanged.
  - Both starts high together: mult_start wins, div_start is dropped.
- Starts are ignored while busy = 1, in MULT, DIV and FINISH.
- MULT:
  - Radix-2 Booth, one step per cycle, WIDTH cycles.
  - 2*WIDTH-bit accumulator with a Booth extra bit.
  - After WIDTH steps, go to FINISH.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Signs latched at start.
  - Quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncate toward zero).
- FINISH:
  - One cycle: hi/lo loaded, done = 1, busy = 0.
  - Then return to IDLE; a start in the following IDLE cycle is accepted.
- Latency:
  - Start accepted at edge N. busy = 1 from N+1 through N+WIDTH.
  - done = 1 and new hi/lo visible in the cycle after edge N+WIDTH+1.
  - hi/lo change only at that edge; they hold their value otherwise.
- Arithmetic:
  - Multiply result: full 2*WIDTH-bit signed product, {hi, lo}.
  - Division overflow: 0x80000000 / -1 wraps, lo = 0x80000000, hi = 0. No overflow flag.
- dzero and done are never high in the same cycle.

Optional Feature:
MULT_DIV_UNSIGNED_EN:
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with the start.
  - When 1, operands are treated as unsigned: multiply yields the unsigned 2*WIDTH-bit product, divide skips sign correction (MULTU/DIVU).
  - When 0, behaviour is identical to the signed operation.
- Not defined: port absent; signed operation only.

Test Plan:
1. mult_start, src_a = 7, src_b = -3 (0xFFFFFFFD) -> done 33 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for exactly 32 cycles.
2. div_start, 100 / 7 -> lo = 14, hi = 2. Then -100 / 7 -> lo = 0xFFFFFFF2, hi = 0xFFFFFFFE. Then 100 / -7 -> lo = 0xFFFFFFF2, hi = 2.
3. Preload hi/lo via a multiply, then div_start with src_b = 0 -> dzero = 1 for one cycle after start; busy stays 0; no done; hi/lo unchanged.
4. div_start, 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. Also mult 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
5. Start a multiply, assert reset at cycle 10 -> busy, done, hi and lo all 0 next cycle; no later done pulse. A new mult 3 * 4 then gives lo = 12, hi = 0.
6. Stimulus:
   - Assert mult_start and div_start together with 6 / 2 -> multiply performed, lo = 12.
   - Pulse div_start mid-operation -> ignored.
   - Back-to-back start in the cycle after done -> accepted.
